// File: rtl/serv_mdu_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Contents: word and counter widths, funct3 operation codes, FSM state
// type, and small helpers that classify operand signedness and form
// operand magnitudes.
package serv_mdu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV)  || (f3 == F3_REM);
  endfunction

  // Operand B is treated as signed for MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Magnitude as an unsigned word; -2^31 maps to 0x80000000.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                          input logic            neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/serv_mdu_addsub.sv
// 33-bit adder/subtractor shared by the multiply and divide iterations.
// Ports:
//   i_a, i_b  operands (33 bits)
//   i_sub     0: o_sum = i_a + i_b, 1: o_sum = i_a - i_b
//   o_sum     33-bit result
//   o_borrow  high when a subtraction went below zero
module serv_mdu_addsub
  import serv_mdu_pkg::*;
(
  input  logic [XLEN:0] i_a,
  input  logic [XLEN:0] i_b,
  input  logic          i_sub,
  output logic [XLEN:0] o_sum,
  output logic          o_borrow
);

  logic [XLEN+1:0] full;

  always_comb begin
    full     = {1'b0, i_a}
             + {1'b0, (i_b ^ {(XLEN+1){i_sub}})}
             + {{(XLEN+1){1'b0}}, i_sub};
    o_sum    = full[XLEN:0];
    // Subtraction as a + ~b + 1: a missing carry out means a borrow.
    o_borrow = i_sub & ~full[XLEN+1];
  end

endmodule

// File: rtl/serv_mdu_seq.sv
// Iterative RV32M multiply/divide unit for the core extension port.
// One bit per cycle through a shared 33-bit adder and a 64-bit shift
// register; every operation takes the same number of cycles.
// Ports:
//   clk       core clock
//   i_rst_n   asynchronous active-low reset
//   i_valid   request level, held until o_ready
//   i_rs1     operand A / dividend
//   i_rs2     operand B / divisor
//   i_funct3  RV32M operation select
//   o_ready   one-cycle completion pulse
//   o_rd      registered result, held until the next completion
//   o_busy    high while an operation is in flight
module serv_mdu_seq
  import serv_mdu_pkg::*;
#(
  parameter int DIV            = 1,
  parameter     RESET_STRATEGY = "MINI"
)
(
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_funct3,
  output logic            o_ready,
  output logic [XLEN-1:0] o_rd,
  output logic            o_busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             valid_q;
  logic             accept;

  // P holds the product; for division R = P[63:32], Q = P[31:0].
  logic [2*XLEN-1:0] p, p_nxt, p_step;
  logic [XLEN-1:0]   b_mag, b_mag_nxt;
  logic              sign_a, sign_a_nxt;
  logic              sign_b, sign_b_nxt;
  logic [2:0]        op, op_nxt;
  logic [XLEN-1:0]   rd_nxt;

  logic              sa, sb;
  logic              div_mode;
  logic [XLEN:0]     add_a, add_b, sum;
  logic              borrow;

  logic              neg_res;
  logic              b_zero;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, result;

  // Rising-edge detect on i_valid keeps a held request from restarting.
  assign accept   = (state == S_IDLE) && i_valid && !valid_q;
  assign div_mode = (DIV != 0) && op[2];

  assign sa = i_rs1[XLEN-1] & a_is_signed(i_funct3);
  assign sb = i_rs2[XLEN-1] & b_is_signed(i_funct3);

  // Multiply adds |B| to the upper half; divide subtracts |B| from the
  // remainder shifted left by one with the next dividend bit appended.
  assign add_a = div_mode ? {1'b0, p[2*XLEN-2:XLEN], p[XLEN-1]}
                          : {1'b0, p[2*XLEN-1:XLEN]};
  assign add_b = {1'b0, b_mag};

  serv_mdu_addsub u_addsub (
    .i_a      (add_a),
    .i_b      (add_b),
    .i_sub    (div_mode),
    .o_sum    (sum),
    .o_borrow (borrow)
  );

  always_comb begin
    p_step = p;
    if (div_mode) begin
      if (borrow)
        p_step = {p[2*XLEN-2:0], 1'b0};
      else
        p_step = {sum[XLEN-1:0], p[XLEN-2:0], 1'b1};
    end else begin
      p_step = {(p[0] ? sum : {1'b0, p[2*XLEN-1:XLEN]}), p[XLEN-1:1]};
    end
  end

  // Divide by zero leaves |A| in R (every step subtracts nothing), so
  // the ordinary remainder sign fix already reproduces rs1; only the
  // quotient needs an explicit override.
  always_comb begin
    neg_res = sign_a ^ sign_b;
    b_zero  = (b_mag == '0);
    prod    = neg_res ? -p : p;
    quo     = p[XLEN-1:0];
    rem     = p[2*XLEN-1:XLEN];
    case (op)
      F3_MUL:                      result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             result = b_zero ? '1 : (neg_res ? -quo : quo);
      default:                     result = sign_a ? -rem : rem;
    endcase
    if ((DIV == 0) && op[2])
      result = '0;
  end

  always_comb begin
    p_nxt      = p;
    b_mag_nxt  = b_mag;
    sign_a_nxt = sign_a;
    sign_b_nxt = sign_b;
    op_nxt     = op;
    rd_nxt     = o_rd;
    if (accept) begin
      sign_a_nxt = sa;
      sign_b_nxt = sb;
      op_nxt     = i_funct3;
      b_mag_nxt  = mag(i_rs2, sb);
      p_nxt      = {{XLEN{1'b0}}, mag(i_rs1, sa)};
    end else if (state == S_CALC) begin
      p_nxt      = p_step;
    end else if (state == S_FIX) begin
      rd_nxt     = result;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      o_ready <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      valid_q <= i_valid;
      o_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_CALC;
            cnt    <= '0;
            o_busy <= 1'b1;
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == '1)
            state <= S_FIX;
        end
        S_FIX: begin
          state   <= S_DONE;
          o_ready <= 1'b1;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  if (RESET_STRATEGY == "MINI") begin : g_dp_rst
    always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        p      <= '0;
        b_mag  <= '0;
        sign_a <= 1'b0;
        sign_b <= 1'b0;
        op     <= '0;
        o_rd   <= '0;
      end else begin
        p      <= p_nxt;
        b_mag  <= b_mag_nxt;
        sign_a <= sign_a_nxt;
        sign_b <= sign_b_nxt;
        op     <= op_nxt;
        o_rd   <= rd_nxt;
      end
    end
  end else begin : g_dp_norst
    always_ff @(posedge clk) begin
      p      <= p_nxt;
      b_mag  <= b_mag_nxt;
      sign_a <= sign_a_nxt;
      sign_b <= sign_b_nxt;
      op     <= op_nxt;
      o_rd   <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_serv_mdu_seq.sv
module tb_serv_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] rs1, rs2;
  logic [2:0]  f3;
  logic        rdy, busy, rdy_nd, busy_nd;
  logic [31:0] rd, rd_nd;

  always #5 clk = ~clk;

  serv_mdu_seq #(.DIV(1), .RESET_STRATEGY("MINI")) dut (
    .clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_rs1(rs1), .i_rs2(rs2),
    .i_funct3(f3), .o_ready(rdy), .o_rd(rd), .o_busy(busy)
  );

  serv_mdu_seq #(.DIV(0), .RESET_STRATEGY("NONE")) dut_nd (
    .clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_rs1(rs1), .i_rs2(rs2),
    .i_funct3(f3), .o_ready(rdy_nd), .o_rd(rd_nd), .o_busy(busy_nd)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Independent reference: 64-bit products of sign/zero-extended operands.
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, pr;
    int sa, sb;
    sa = a; sb = b;
    xa = (op == 3'b001 || op == 3'b010) ? {{32{a[31]}}, a} : {32'h0, a};
    xb = (op == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
    pr = xa * xb;
    case (op)
      3'b000: return pr[31:0];
      3'b001, 3'b010, 3'b011: return pr[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 100);
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    @(negedge clk);
    f3 = op; rs1 = a; rs2 = b; valid = 1'b1;
    wait_ready(n);
    check({name, " latency"}, 32'(n), 32'd34);
    check({name, " rd"}, rd, exp);
    check({name, " busy_at_ready"}, 32'(busy), 32'd1);
    check({name, " rd_nodiv"}, rd_nd, op[2] ? 32'h0 : exp);
    check({name, " ready_nodiv"}, 32'(rdy_nd), 32'd1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    int n, extra;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst_n = 1'b0; valid = 1'b0; rs1 = '0; rs2 = '0; f3 = '0;

    vecs.push_back('{3'b000, 32'd7,        32'd6,        32'h0000002A});
    vecs.push_back('{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF});
    vecs.push_back('{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1});
    vecs.push_back('{3'b011, 32'h80000000, 32'd4,        32'h00000002});
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
    vecs.push_back('{3'b101, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF});
    vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'h10,       32'h0000000F});
    vecs.push_back('{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD});
    vecs.push_back('{3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF});
    vecs.push_back('{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF});
    vecs.push_back('{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF});
    vecs.push_back('{3'b110, 32'h1234,     32'd0,        32'h00001234});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9});
    vecs.push_back('{3'b111, 32'h1234,     32'd0,        32'h00001234});
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000});

    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(rdy), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rd", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, issued back-to-back with one low cycle between.
    foreach (vecs[i])
      run_op($sformatf("vec%0d f3=%0d", i, vecs[i].f3), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Request held high past completion must not restart.
    @(negedge clk);
    f3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9; valid = 1'b1;
    wait_ready(n);
    check("hold latency", 32'(n), 32'd34);
    check("hold rd", rd, 32'd81);
    extra = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (rdy) extra++;
    end
    @(negedge clk);
    valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rdy) extra++;
    end
    check("hold extra_ready", 32'(extra), 32'd0);
    check("hold busy_after", 32'(busy), 32'd0);

    // Reset asserted with cnt=10 aborts; a held valid afterwards is new.
    @(negedge clk);
    f3 = 3'b000; rs1 = 32'd7; rs2 = 32'd6; valid = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rdy) extra++;
    end
    check("abort no_ready", 32'(extra), 32'd0);
    check("abort rd_reset", rd, 32'h0);
    @(negedge clk);
    f3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; rst_n = 1'b1;
    wait_ready(n);
    check("post_reset latency", 32'(n), 32'd34);
    check("post_reset rd", rd, 32'd14);
    @(negedge clk);
    valid = 1'b0;

    // Random operations against the reference model.
    for (int k = 0; k < 300; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
      run_op($sformatf("rand%0d f3=%0d a=%08h b=%08h", k, rop, ra, rb), rop, ra, rb, ref_op(rop, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
